// File: rtl/dct_pkg.sv
// dct_pkg: shared defaults, FSM states and the round/saturate helper for the DCT matrix multiplier
package dct_pkg;
   localparam int N_DEF          = 4;
   localparam int DATA_W_DEF     = 13;
   localparam int OUT_W_DEF      = 13;
   localparam int FRAC_SHIFT_DEF = 0;

   typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

   typedef struct packed {
      logic              clip;
      logic signed [63:0] val;
   } rs_t;

   // Round half toward +inf, then clip to the signed out_w range; clip reports whether clipping happened.
   function automatic rs_t round_sat(input logic signed [63:0] acc, input int frac, input int out_w);
      logic signed [63:0] r, hi, lo;
      rs_t o;
      r = (frac > 0) ? (acc + (64'sd1 <<< (frac - 1))) >>> frac : acc;
      hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (out_w - 1));
      o.clip = (r > hi) || (r < lo);
      o.val = (r > hi) ? hi : (r < lo) ? lo : r;
      return o;
   endfunction
endpackage

// File: rtl/dct_mac_sat.sv
// dct_mac_sat: signed multiply-accumulate with clear/last-term control and rounded, saturated element output
module dct_mac_sat
   import dct_pkg::*;
#(
   parameter int DATA_W     = DATA_W_DEF,
   parameter int ACC_W      = 2 * DATA_W_DEF + 2,
   parameter int OUT_W      = OUT_W_DEF,
   parameter int FRAC_SHIFT = FRAC_SHIFT_DEF
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     clr_i,
   input  logic                     en_i,
   input  logic                     last_i,
   input  logic signed [DATA_W-1:0] a_i,
   input  logic signed [DATA_W-1:0] b_i,
   output logic signed [OUT_W-1:0]  res_o,
   output logic                     clip_o
);
   logic signed [2*DATA_W-1:0] prod;
   logic signed [ACC_W-1:0]    acc_q, acc_d, sum;
   rs_t                        rs;

   assign prod   = a_i * b_i;
   assign sum    = acc_q + ACC_W'(prod);
   assign rs     = round_sat(64'(sum), FRAC_SHIFT, OUT_W);
   assign res_o  = rs.val[OUT_W-1:0];
   assign clip_o = rs.clip;

   // Accumulate one product per enabled cycle; the final term of an element restarts from zero.
   always_comb acc_d = clr_i ? '0 : en_i ? (last_i ? '0 : sum) : acc_q;

   // Accumulator register.
   always_ff @(posedge clk or posedge reset)
      if (reset) acc_q <= '0;
      else       acc_q <= acc_d;
endmodule

// File: rtl/dct_matmul_seq.sv
// dct_matmul_seq: sequential NxN signed matrix multiply (A x B or A x B^T) with one time-multiplexed MAC
module dct_matmul_seq
   import dct_pkg::*;
#(
   parameter int N          = N_DEF,
   parameter int DATA_W     = DATA_W_DEF,
   parameter int OUT_W      = OUT_W_DEF,
   parameter int FRAC_SHIFT = FRAC_SHIFT_DEF,
   parameter int ACC_W      = 2 * DATA_W + $clog2(N)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [N*N*DATA_W-1:0]     a_mat,
   input  logic [N*N*DATA_W-1:0]     b_mat,
   input  logic                      transpose_b,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [N*N*OUT_W-1:0]      res_mat,
   output logic                      sat_flag,
   output logic                      busy
);
   localparam int             CW   = $clog2(N);
   localparam logic [CW-1:0]  LAST = CW'(N - 1);

   state_t                     state_q, state_d;
   logic [N*N*DATA_W-1:0]      a_q, b_q;
   logic                       tb_q;
   logic [CW-1:0]              i_q, j_q, k_q;
   logic [N*N*OUT_W-1:0]       res_q;
   logic                       sat_q;
   logic                       accept, last_k, last_el, clip;
   logic signed [DATA_W-1:0]   a_el, b_el;
   logic signed [OUT_W-1:0]    el;
   int                         a_idx, b_idx, r_idx;

   assign accept  = in_valid && in_ready;
   assign last_k  = k_q == LAST;
   assign last_el = last_k && (i_q == LAST) && (j_q == LAST);

   // Operand and result element addressing from the i/j/k counters.
   always_comb begin
      a_idx = (int'(i_q) * N + int'(k_q)) * DATA_W;
      b_idx = (tb_q ? int'(j_q) * N + int'(k_q) : int'(k_q) * N + int'(j_q)) * DATA_W;
      r_idx = (int'(i_q) * N + int'(j_q)) * OUT_W;
      a_el  = a_q[a_idx +: DATA_W];
      b_el  = b_q[b_idx +: DATA_W];
   end

   dct_mac_sat #(
      .DATA_W     (DATA_W),
      .ACC_W      (ACC_W),
      .OUT_W      (OUT_W),
      .FRAC_SHIFT (FRAC_SHIFT)
   ) u_mac (
      .clk    (clk),
      .reset  (reset),
      .clr_i  (accept),
      .en_i   (state_q == MAC),
      .last_i (last_k),
      .a_i    (a_el),
      .b_i    (b_el),
      .res_o  (el),
      .clip_o (clip)
   );

   // FSM state register.
   always_ff @(posedge clk or posedge reset)
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;

   // Next state: accept a pair, run N^3 MAC cycles, hold the result until it is consumed.
   always_comb
      state_d = (state_q == IDLE) ? (in_valid ? MAC : IDLE) :
                (state_q == MAC)  ? (last_el ? DONE : MAC) :
                (state_q == DONE) ? (out_ready ? IDLE : DONE) : IDLE;

   // Handshake and status outputs decoded from the state.
   always_comb begin
      in_ready  = state_q == IDLE;
      busy      = state_q != IDLE;
      out_valid = state_q == DONE;
      res_mat   = res_q;
      sat_flag  = sat_q;
   end

   // Operand capture, k-fastest counters, element write-back and sticky saturation flag.
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         a_q   <= '0;
         b_q   <= '0;
         tb_q  <= 1'b0;
         i_q   <= '0;
         j_q   <= '0;
         k_q   <= '0;
         res_q <= '0;
         sat_q <= 1'b0;
      end else if (accept) begin
         a_q   <= a_mat;
         b_q   <= b_mat;
         tb_q  <= transpose_b;
         i_q   <= '0;
         j_q   <= '0;
         k_q   <= '0;
         sat_q <= 1'b0;
      end else if (state_q == MAC) begin
         k_q <= last_k ? '0 : k_q + 1'b1;
         if (last_k) begin
            j_q <= (j_q == LAST) ? '0 : j_q + 1'b1;
            if (j_q == LAST) i_q <= (i_q == LAST) ? '0 : i_q + 1'b1;
            res_q[r_idx +: OUT_W] <= el;
            sat_q <= sat_q | clip;
         end
      end
endmodule

// File: tb/tb_dct_matmul_seq.sv
// tb_dct_matmul_seq: scoreboard bench for two instances (FRAC_SHIFT 0 and 2) of the DCT matrix multiplier
module tb_dct_matmul_seq;
   localparam int N  = 4;
   localparam int W  = 13;
   localparam int VW = N * N * W;

   typedef int mat_t [4][4];
   typedef struct {
      logic [VW-1:0] res;
      logic          sat;
   } exp_t;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          in_valid [2];
   logic          in_ready [2];
   logic          tr [2];
   logic          out_valid [2];
   logic          out_ready [2];
   logic          sat_flag [2];
   logic          busy [2];
   logic [VW-1:0] a_mat [2];
   logic [VW-1:0] b_mat [2];
   logic [VW-1:0] res_mat [2];

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   mat_t id, bseq, f4095, fm4096, b6, bm6, b5;

   always #5 clk = ~clk;

   dct_matmul_seq #(.N(N), .DATA_W(W), .OUT_W(W), .FRAC_SHIFT(0)) dut0 (
      .clk(clk), .reset(reset), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .a_mat(a_mat[0]), .b_mat(b_mat[0]), .transpose_b(tr[0]), .out_valid(out_valid[0]),
      .out_ready(out_ready[0]), .res_mat(res_mat[0]), .sat_flag(sat_flag[0]), .busy(busy[0])
   );

   dct_matmul_seq #(.N(N), .DATA_W(W), .OUT_W(W), .FRAC_SHIFT(2)) dut1 (
      .clk(clk), .reset(reset), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .a_mat(a_mat[1]), .b_mat(b_mat[1]), .transpose_b(tr[1]), .out_valid(out_valid[1]),
      .out_ready(out_ready[1]), .res_mat(res_mat[1]), .sat_flag(sat_flag[1]), .busy(busy[1])
   );

   task automatic check(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [VW-1:0] pack(input mat_t m);
      logic [VW-1:0] v = '0;
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++)
            v[(r*N+c)*W +: W] = W'(m[r][c]);
      return v;
   endfunction

   function automatic exp_t model(input mat_t a, input mat_t b, input bit t, input int frac);
      exp_t   e;
      longint s;
      e.res = '0;
      e.sat = 1'b0;
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) begin
            s = 0;
            for (int k = 0; k < N; k++)
               s += longint'(a[r][k]) * longint'(t ? b[c][k] : b[k][c]);
            if (frac > 0) s = (s + (longint'(1) << (frac - 1))) >>> frac;
            if (s > 4095) begin s = 4095; e.sat = 1'b1; end
            if (s < -4096) begin s = -4096; e.sat = 1'b1; end
            e.res[(r*N+c)*W +: W] = W'(s);
         end
      return e;
   endfunction

   task automatic run_mat(input int u, input mat_t a, input mat_t b, input bit t, input int hold);
      exp_t          e;
      int            cnt;
      bit            bad;
      logic [VW-1:0] r0;
      logic          s0;
      sb.push_back(model(a, b, t, (u == 1) ? 2 : 0));
      check("in_ready_idle", in_ready[u], 1);
      a_mat[u]    = pack(a);
      b_mat[u]    = pack(b);
      tr[u]       = t;
      in_valid[u] = 1'b1;
      @(posedge clk); #1;
      in_valid[u] = 1'b0;
      a_mat[u]    = ~a_mat[u];
      b_mat[u]    = ~b_mat[u];
      tr[u]       = ~t;
      cnt = 0;
      bad = 0;
      while (!out_valid[u] && cnt < 200) begin
         if (in_ready[u] || !busy[u]) bad = 1;
         @(posedge clk); #1;
         cnt++;
      end
      check("latency", cnt, 64);
      check("in_ready_during_mac", bad, 0);
      if (hold > 0) begin
         r0  = res_mat[u];
         s0  = sat_flag[u];
         bad = 0;
         for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            if (res_mat[u] !== r0 || sat_flag[u] !== s0 || in_ready[u] || !out_valid[u]) bad = 1;
         end
         check("backpressure_hold", bad, 0);
      end
      e = sb.pop_front();
      check("res_mat", res_mat[u], e.res);
      check("sat_flag", sat_flag[u], e.sat);
      out_ready[u] = 1'b1;
      @(posedge clk); #1;
      out_ready[u] = 1'b0;
      check("out_valid_drop", out_valid[u], 0);
      check("in_ready_return", in_ready[u], 1);
   endtask

   initial begin
      for (int u = 0; u < 2; u++) begin
         in_valid[u]  = 1'b0;
         out_ready[u] = 1'b0;
         tr[u]        = 1'b0;
         a_mat[u]     = '0;
         b_mat[u]     = '0;
      end
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) begin
            id[r][c]     = (r == c) ? 1 : 0;
            bseq[r][c]   = 4 * r + c;
            f4095[r][c]  = 4095;
            fm4096[r][c] = -4096;
            b6[r][c]     = 6;
            bm6[r][c]    = -6;
            b5[r][c]     = 5;
         end
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready", in_ready[0], 1);
      check("rst_out_valid", out_valid[0], 0);
      check("rst_busy", busy[0], 0);
      check("rst_sat", sat_flag[0], 0);
      check("rst_res", res_mat[0], '0);
      reset = 1'b0;
      @(posedge clk); #1;
      run_mat(0, id, bseq, 1'b0, 0);
      run_mat(0, id, bseq, 1'b1, 0);
      run_mat(0, f4095, f4095, 1'b0, 10);
      run_mat(0, fm4096, f4095, 1'b0, 0);
      run_mat(1, id, b6, 1'b0, 0);
      run_mat(1, id, bm6, 1'b0, 0);
      run_mat(1, id, b5, 1'b0, 0);
      a_mat[0]    = pack(f4095);
      b_mat[0]    = pack(f4095);
      tr[0]       = 1'b0;
      in_valid[0] = 1'b1;
      @(posedge clk); #1;
      in_valid[0] = 1'b0;
      repeat (19) @(posedge clk);
      #1;
      check("mid_mac_busy", busy[0], 1);
      reset = 1'b1;
      #1;
      check("abort_res", res_mat[0], '0);
      check("abort_sat", sat_flag[0], 0);
      check("abort_busy", busy[0], 0);
      check("abort_in_ready", in_ready[0], 1);
      check("abort_out_valid", out_valid[0], 0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      run_mat(0, id, bseq, 1'b0, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
